// File: rtl/reaction_timer.sv
// Reaction timer: start a round, wait a pseudo-random number of ms, light the
// LED, then count whole milliseconds until the player presses the button.
// A press before the LED lights is a false start and reports 0 ms.
module reaction_timer #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_MASK    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        b,
    output logic        led,
    output logic [23:0] timecount,
    output logic        done,
    output logic        false_start,
    output logic        busy
);

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_MS + RAND_MASK + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [23:0]      MS_MAX    = 24'hFFFFFF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COUNT, S_DONE} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic                 b_prev_reg;
    logic [15:0]          lfsr_reg;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [DELAY_W-1:0]   delay_reg, delay_next;
    logic [23:0]          ms_reg, ms_next;
    logic [23:0]          timecount_reg, timecount_next;
    logic                 led_reg, led_next;
    logic                 done_reg, done_next;
    logic                 fs_reg, fs_next;
    logic                 busy_reg, busy_next;

    logic                 press;
    logic                 tick;
    logic                 lfsr_fb;
    logic [23:0]          ms_inc;
    logic [DELAY_W-1:0]   delay_load;

    // Synchronised button level (sync_reg[1]) and its previous value, for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg   <= 2'b00;
            b_prev_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], b};
            b_prev_reg <= sync_reg[1];
        end
    end

    // Free-running LFSR, taps 16/14/13/11 in right-shift form
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_reg <= LFSR_SEED;
        else       lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
    end

    assign lfsr_fb    = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign press      = sync_reg[1] & ~b_prev_reg;
    assign tick       = (div_reg == DIV_LAST);
    assign ms_inc     = (ms_reg == MS_MAX) ? ms_reg : ms_reg + 24'd1;
    assign delay_load = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_reg & 16'(RAND_MASK));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; a press outranks the final WAIT tick so it counts as a false start
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_WAIT;
            S_WAIT: begin
                if (press)                                      state_next = S_DONE;
                else if (tick && (delay_reg <= DELAY_W'(1)))    state_next = S_COUNT;
            end
            S_COUNT: if (press) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_WAIT;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        delay_next     = delay_reg;
        ms_next        = ms_reg;
        timecount_next = timecount_reg;
        fs_next        = fs_reg;
        done_next      = 1'b0;
        // divider restarts on every state entry so the first tick is a full ms later
        if (state_next != state_reg || tick) div_next = '0;
        else                                 div_next = div_reg + DIV_W'(1);
        led_next  = (state_next == S_COUNT);
        busy_next = (state_next == S_WAIT) || (state_next == S_COUNT);
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    delay_next     = delay_load;
                    timecount_next = '0;
                    fs_next        = 1'b0;
                end
            end
            S_WAIT: begin
                if (press) begin
                    timecount_next = '0;
                    fs_next        = 1'b1;
                    done_next      = 1'b1;
                end else if (tick) begin
                    if (delay_reg != '0) delay_next = delay_reg - DELAY_W'(1);
                    if (delay_reg <= DELAY_W'(1)) ms_next = '0;
                end
            end
            S_COUNT: begin
                if (press) begin
                    // a tick landing with the press still counts toward the result
                    timecount_next = tick ? ms_inc : ms_reg;
                    done_next      = 1'b1;
                end else if (tick) begin
                    ms_next = ms_inc;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg       <= '0;
            delay_reg     <= '0;
            ms_reg        <= '0;
            timecount_reg <= '0;
            led_reg       <= 1'b0;
            done_reg      <= 1'b0;
            fs_reg        <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            div_reg       <= div_next;
            delay_reg     <= delay_next;
            ms_reg        <= ms_next;
            timecount_reg <= timecount_next;
            led_reg       <= led_next;
            done_reg      <= done_next;
            fs_reg        <= fs_next;
            busy_reg      <= busy_next;
        end
    end

    assign led         = led_reg;
    assign timecount   = timecount_reg;
    assign done        = done_reg;
    assign false_start = fs_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a result scoreboard and a reference LFSR.
module tb_reaction_timer;

    localparam int TD   = 4;
    localparam int MIN  = 2;
    localparam int MASK = 3;

    logic        clk = 1'b0;
    logic        reset, start, b;
    logic        led, done, false_start, busy;
    logic [23:0] timecount;

    typedef struct {
        logic [23:0] tc;
        logic        fs;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_lfsr;
    logic        led_seen;

    reaction_timer #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN), .RAND_MASK(MASK)) dut (
        .clk(clk), .reset(reset), .start(start), .b(b), .led(led),
        .timecount(timecount), .done(done), .false_start(false_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11 feed the MSB, register shifts right
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
        return {fb, s[15:1]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_lfsr <= 16'hACE1;
        else       model_lfsr <= lfsr_step(model_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [23:0] tc, input logic fs);
        exp_t e;
        e.tc = tc;
        e.fs = fs;
        sb.push_back(e);
    endtask

    // Waits for led; returns the number of edges elapsed since the call
    task automatic wait_led(input string tag, output int cyc);
        cyc = 0;
        while (!led && cyc < 200) begin
            step(1);
            cyc++;
        end
        chk({tag, "_led_timeout"}, 32'(cyc < 200), 32'd1);
    endtask

    // Waits for the done pulse after a press and compares against the scoreboard
    task automatic wait_result(input string tag);
        int   cyc;
        exp_t e;
        cyc      = 0;
        led_seen = led;
        while (!done && cyc < 50) begin
            step(1);
            cyc++;
            if (led) led_seen = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(cyc), 32'd3);
        chk({tag, "_timecount"}, 32'(timecount), 32'(e.tc));
        chk({tag, "_false_start"}, 32'(false_start), 32'(e.fs));
        $display("round %s: timecount=%0d false_start=%0b latency=%0d", tag, timecount, false_start, cyc);
        step(1);
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_led_off"}, 32'(led), 32'd0);
    endtask

    initial begin
        int cyc;
        int exp_delay;
        int n;
        int done_cnt;

        reset = 1'b1; start = 1'b0; b = 1'b0;
        #12;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fs", 32'(false_start), 32'd0);
        chk("rst_timecount", 32'(timecount), 32'd0);
        @(negedge clk) reset = 1'b0;
        step(2);

        // Normal round with delay check against the reference LFSR
        exp_delay = MIN + int'(model_lfsr & 16'(MASK));
        start = 1'b1; step(1); start = 1'b0;
        chk("normal_busy", 32'(busy), 32'd1);
        chk("normal_led_early", 32'(led), 32'd0);
        wait_led("normal", cyc);
        chk("normal_wait_len", 32'(cyc), 32'(exp_delay * TD));
        n = 40;
        step(n);
        b = 1'b1;
        // press at n edges after LED-on lands n+3 edges after LED-on
        push_exp(24'((n + 3) / TD), 1'b0);
        wait_result("normal");
        chk("normal_busy_end", 32'(busy), 32'd0);
        b = 1'b0; step(3);

        // False start
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        b = 1'b1;
        push_exp(24'd0, 1'b1);
        wait_result("false_start");
        chk("fs_led_never", 32'(led_seen), 32'd0);
        b = 1'b0; step(4);
        chk("fs_hold_tc", 32'(timecount), 32'd0);
        chk("fs_hold_flag", 32'(false_start), 32'd1);
        chk("fs_hold_busy", 32'(busy), 32'd0);

        // Held button: already high at LED-on, result only after release and re-press
        b = 1'b1; step(5);
        chk("held_done_ignored", 32'(false_start), 32'd1);
        start = 1'b1; step(1); start = 1'b0;
        wait_led("held", cyc);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (done) done_cnt++;
        end
        chk("held_no_result", 32'(done_cnt), 32'd0);
        chk("held_still_count", 32'(led), 32'd1);
        b = 1'b0; step(4);
        b = 1'b1;
        push_exp(24'((16 + 3) / TD), 1'b0);
        wait_result("held");
        b = 1'b0; step(3);

        // Saturation and start ignored in COUNT
        start = 1'b1; step(1); start = 1'b0;
        wait_led("sat", cyc);
        step(1);
        force dut.ms_reg = 24'hFFFFFD;
        #1 release dut.ms_reg;
        start = 1'b1; step(1); start = 1'b0;
        chk("ignore_start_led", 32'(led), 32'd1);
        chk("ignore_start_busy", 32'(busy), 32'd1);
        step(14);
        b = 1'b1;
        push_exp(24'hFFFFFF, 1'b0);
        wait_result("saturate");
        b = 1'b0; step(3);

        // Reset mid-round acts without a clock edge
        start = 1'b1; step(1); start = 1'b0;
        wait_led("midreset", cyc);
        step(5);
        #3 reset = 1'b1;
        #1;
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_timecount", 32'(timecount), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fs", 32'(false_start), 32'd0);
        @(negedge clk) reset = 1'b0;
        step(1);

        // 3-cycle glitch in IDLE changes nothing
        b = 1'b1; step(3); b = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (done || busy) done_cnt++;
        end
        chk("glitch_idle", 32'(done_cnt), 32'd0);
        chk("glitch_timecount", 32'(timecount), 32'd0);

        // New round after reset
        exp_delay = MIN + int'(model_lfsr & 16'(MASK));
        start = 1'b1; step(1); start = 1'b0;
        wait_led("after_reset", cyc);
        chk("after_reset_wait_len", 32'(cyc), 32'(exp_delay * TD));
        step(8);
        b = 1'b1;
        push_exp(24'((8 + 3) / TD), 1'b0);
        wait_result("after_reset");
        b = 1'b0; step(2);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
